// File: rtl/alu_pkg.sv
// Shared opcode and FSM state encodings for the sequential ALU.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD    = 4'b0010,
    OP_SUB    = 4'b0011,
    OP_SHL    = 4'b0100,
    OP_SHR    = 4'b0101,
    OP_AND    = 4'b0110,
    OP_OR     = 4'b0111,
    OP_XOR    = 4'b1000,
    OP_POPCNT = 4'b1001,
    OP_CMP    = 4'b1010,
    OP_CLRF   = 4'b1011,
    OP_MUL    = 4'b1100
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_iter_unit.sv
// Iterative datapath: one bit of shift / popcount / shift-add multiply per step.
// Multiply hardware exists only when ALU_SEQ_MUL_EN is defined.
module alu_iter_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNTW  = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             step,
  input  op_e              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [CNTW-1:0]  k,
  output logic             finish,
  output logic [WIDTH-1:0] res
`ifdef ALU_SEQ_MUL_EN
  ,
  output logic             mul_hi_nz
`endif
);

  op_e              op_r;
  logic [CNTW-1:0]  cnt;
  logic [WIDTH-1:0] sh;
  logic [CNTW-1:0]  pop;
`ifdef ALU_SEQ_MUL_EN
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mc;
  logic [WIDTH-1:0]   mb;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r <= op_e'('0);
      cnt  <= '0;
      sh   <= '0;
      pop  <= '0;
`ifdef ALU_SEQ_MUL_EN
      acc  <= '0;
      mc   <= '0;
      mb   <= '0;
`endif
    end else if (start) begin
      op_r <= op;
      cnt  <= k;
      // Popcount walks B; shifts walk A.
      sh   <= (op == OP_POPCNT) ? b : a;
      pop  <= '0;
`ifdef ALU_SEQ_MUL_EN
      acc  <= '0;
      mc   <= {{WIDTH{1'b0}}, a};
      mb   <= b;
`endif
    end else if (step) begin
      cnt <= cnt - CNTW'(1);
      case (op_r)
        OP_SHL: sh <= sh << 1;
        OP_SHR: sh <= sh >> 1;
        OP_POPCNT: begin
          pop <= pop + CNTW'(sh[0]);
          sh  <= sh >> 1;
        end
`ifdef ALU_SEQ_MUL_EN
        OP_MUL: begin
          if (mb[0]) acc <= acc + mc;
          mc <= mc << 1;
          mb <= mb >> 1;
        end
`endif
        default: ;
      endcase
    end
  end

  assign finish = (cnt == '0);

  always_comb begin
    res = sh;
    case (op_r)
      OP_POPCNT: res = WIDTH'(pop);
`ifdef ALU_SEQ_MUL_EN
      OP_MUL:    res = acc[WIDTH-1:0];
`endif
      default:   res = sh;
    endcase
  end

`ifdef ALU_SEQ_MUL_EN
  assign mul_hi_nz = |acc[2*WIDTH-1:WIDTH];
`endif

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle accumulator ALU with persistent z/c/n/v flags and valid/ready handshakes.
// Optional iterative MUL (opcode 1100) enabled by defining ALU_SEQ_MUL_EN.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNTW  = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] acc_in,
  input  logic [WIDTH-1:0] reg_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             z,
  output logic             c,
  output logic             n,
  output logic             v
);

  localparam int              M      = WIDTH - 1;
  localparam logic [WIDTH-1:0] W_LIM  = WIDTH'(WIDTH);
  localparam logic [CNTW-1:0]  K_FULL = CNTW'(WIDTH);

  state_e           state, state_nxt;
  op_e              op_r;
  logic [WIDTH-1:0] a_r, b_r;
  logic             start, step, commit, finish;
  logic [CNTW-1:0]  k;
  logic [WIDTH-1:0] iter_res;
  logic [WIDTH:0]   sum, diff;
  logic [WIDTH-1:0] res_nxt;
  logic             z_nxt, c_nxt, n_nxt, v_nxt;
`ifdef ALU_SEQ_MUL_EN
  logic             mul_hi_nz;
`endif

  // Every accepted op passes through EXEC; k=0 means it commits on the next edge.
  always_comb begin
    k = '0;
    case (op_e'(op))
      OP_SHL, OP_SHR: k = (reg_in >= W_LIM) ? K_FULL : reg_in[CNTW-1:0];
      OP_POPCNT:      k = K_FULL;
`ifdef ALU_SEQ_MUL_EN
      OP_MUL:         k = K_FULL;
`endif
      default:        k = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    step      = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: if (in_valid) begin
        start     = 1'b1;
        state_nxt = EXEC;
      end
      EXEC: if (finish) begin
        commit    = 1'b1;
        state_nxt = DONE;
      end else begin
        step = 1'b1;
      end
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  alu_iter_unit #(
    .WIDTH(WIDTH),
    .CNTW (CNTW)
  ) u_iter (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .step     (step),
    .op       (op_e'(op)),
    .a        (acc_in),
    .b        (reg_in),
    .k        (k),
    .finish   (finish),
    .res      (iter_res)
`ifdef ALU_SEQ_MUL_EN
    ,
    .mul_hi_nz(mul_hi_nz)
`endif
  );

  assign sum  = {1'b0, a_r} + {1'b0, b_r} + {{WIDTH{1'b0}}, c};
  assign diff = {1'b0, a_r} - {1'b0, b_r};

  always_comb begin
    res_nxt = '0;
    z_nxt   = z;
    c_nxt   = c;
    n_nxt   = n;
    v_nxt   = v;
    case (op_r)
      OP_ADD: begin
        res_nxt = sum[M:0];
        c_nxt   = sum[WIDTH];
        v_nxt   = (a_r[M] == b_r[M]) && (sum[M] != a_r[M]);
      end
      OP_SUB: begin
        res_nxt = diff[M:0];
        c_nxt   = diff[WIDTH];
        v_nxt   = (a_r[M] != b_r[M]) && (diff[M] != a_r[M]);
      end
      OP_SHL, OP_SHR, OP_POPCNT: res_nxt = iter_res;
      OP_AND: res_nxt = a_r & b_r;
      OP_OR:  res_nxt = a_r | b_r;
      OP_XOR: res_nxt = a_r ^ b_r;
      OP_CMP: begin
        z_nxt = (a_r == b_r);
        n_nxt = (a_r < b_r);
      end
      OP_CLRF: c_nxt = 1'b0;
`ifdef ALU_SEQ_MUL_EN
      OP_MUL: begin
        res_nxt = iter_res;
        c_nxt   = mul_hi_nz;
      end
`endif
      default: res_nxt = '0;
    endcase
  end

  // Result and flags move only on the commit edge, so they hold under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r   <= op_e'('0);
      a_r    <= '0;
      b_r    <= '0;
      result <= '0;
      z      <= 1'b0;
      c      <= 1'b0;
      n      <= 1'b0;
      v      <= 1'b0;
    end else begin
      if (start) begin
        op_r <= op_e'(op);
        a_r  <= acc_in;
        b_r  <= reg_in;
      end
      if (commit) begin
        result <= res_nxt;
        z      <= z_nxt;
        c      <= c_nxt;
        n      <= n_nxt;
        v      <= v_nxt;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed table-driven bench for alu_seq (WIDTH=8); follows ALU_SEQ_MUL_EN when defined.
module tb_alu_seq;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] op;
  logic [7:0] acc_in;
  logic [7:0] reg_in;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic       z, c, n, v;

  int n_chk  = 0;
  int n_pass = 0;

  alu_seq #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .acc_in   (acc_in),
    .reg_in   (reg_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .z        (z),
    .c        (c),
    .n        (n),
    .v        (v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // flags are packed {z,c,n,v}; keep=1 means all flags must equal their pre-op values
  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    int         lat;
    logic [3:0] mask;
    logic [3:0] flg;
    bit         keep;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic do_op(input logic [3:0] o, input logic [7:0] aa, input logic [7:0] bb,
                       output int lat);
    int w;
    w = 0;
    while (!in_ready && w < 20) begin
      @(posedge clk); #1; w++;
    end
    in_valid = 1'b1;
    op       = o;
    acc_in   = aa;
    reg_in   = bb;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got stuck, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int         lat;
    logic [3:0] prev;
    logic [3:0] got;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = 4'h0; acc_in = 8'h00; reg_in = 8'h00;

    vecs.push_back('{4'h2, 8'hF0, 8'h20, 8'h10, 1, 4'b0101, 4'b0100, 1'b0}); // ADD carry out
    vecs.push_back('{4'h2, 8'h01, 8'h01, 8'h03, 1, 4'b0101, 4'b0000, 1'b0}); // ADD uses c
    vecs.push_back('{4'h2, 8'hF0, 8'h20, 8'h10, 1, 4'b0101, 4'b0100, 1'b0});
    vecs.push_back('{4'hB, 8'h55, 8'h66, 8'h00, 1, 4'b0100, 4'b0000, 1'b0}); // CLRF
    vecs.push_back('{4'h2, 8'h7F, 8'h01, 8'h80, 1, 4'b0101, 4'b0001, 1'b0}); // ADD overflow
    vecs.push_back('{4'h3, 8'h80, 8'h01, 8'h7F, 1, 4'b0101, 4'b0001, 1'b0}); // SUB overflow
    vecs.push_back('{4'h3, 8'h02, 8'h05, 8'hFD, 1, 4'b0101, 4'b0100, 1'b0}); // SUB borrow
    vecs.push_back('{4'hA, 8'h03, 8'h03, 8'h00, 1, 4'b1110, 4'b1100, 1'b0}); // CMP eq, c kept
    vecs.push_back('{4'hA, 8'h02, 8'h09, 8'h00, 1, 4'b1110, 4'b0110, 1'b0}); // CMP lt
    vecs.push_back('{4'hA, 8'h09, 8'h02, 8'h00, 1, 4'b1110, 4'b0100, 1'b0}); // CMP gt
    vecs.push_back('{4'h4, 8'h81, 8'h03, 8'h08, 4, 4'b0000, 4'b0000, 1'b0}); // SHL 3
    vecs.push_back('{4'h5, 8'h81, 8'h00, 8'h81, 1, 4'b0000, 4'b0000, 1'b0}); // SHR 0
    vecs.push_back('{4'h4, 8'hFF, 8'hC8, 8'h00, 9, 4'b0000, 4'b0000, 1'b0}); // SHL 200
    vecs.push_back('{4'h5, 8'h80, 8'h07, 8'h01, 8, 4'b0000, 4'b0000, 1'b0}); // SHR 7
    vecs.push_back('{4'h4, 8'h01, 8'h07, 8'h80, 8, 4'b0000, 4'b0000, 1'b0}); // SHL 7
    vecs.push_back('{4'h9, 8'h00, 8'hB5, 8'h05, 9, 4'b0000, 4'b0000, 1'b0}); // POPCNT
    vecs.push_back('{4'h9, 8'hFF, 8'hFF, 8'h08, 9, 4'b0000, 4'b0000, 1'b0}); // POPCNT all ones
    vecs.push_back('{4'h6, 8'hF0, 8'h3C, 8'h30, 1, 4'b0000, 4'b0000, 1'b0});
    vecs.push_back('{4'h7, 8'hF0, 8'h0F, 8'hFF, 1, 4'b0000, 4'b0000, 1'b0});
    vecs.push_back('{4'h8, 8'hFF, 8'h0F, 8'hF0, 1, 4'b0000, 4'b0000, 1'b0});
    vecs.push_back('{4'h0, 8'hA5, 8'h5A, 8'h00, 1, 4'b1111, 4'b0000, 1'b1}); // unknown op
    vecs.push_back('{4'hF, 8'h12, 8'h34, 8'h00, 1, 4'b1111, 4'b0000, 1'b1});
`ifdef ALU_SEQ_MUL_EN
    vecs.push_back('{4'hC, 8'h10, 8'h11, 8'h10, 9, 4'b0100, 4'b0100, 1'b0}); // MUL high nonzero
    vecs.push_back('{4'hC, 8'h0F, 8'h03, 8'h2D, 9, 4'b0100, 4'b0000, 1'b0});
`else
    vecs.push_back('{4'hC, 8'h10, 8'h11, 8'h00, 1, 4'b1111, 4'b0000, 1'b1}); // MUL disabled
`endif

    repeat (2) @(posedge clk);
    #1;
    check("reset_result", result, 8'h00);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_flags", {z, c, n, v}, 4'b0000);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("reset_in_ready", in_ready, 1'b1);

    foreach (vecs[i]) begin
      prev = {z, c, n, v};
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, lat);
      got = {z, c, n, v};
      check($sformatf("vec%0d_result", i), result, vecs[i].res);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      if (vecs[i].keep)
        check($sformatf("vec%0d_flags_kept", i), got, prev);
      else if (vecs[i].mask != 4'b0000)
        check($sformatf("vec%0d_flags", i), got & vecs[i].mask, vecs[i].flg & vecs[i].mask);
      release_out();
    end

    // Backpressure: result/flags frozen, new offers ignored while DONE is stalled
    do_op(4'hB, 8'h00, 8'h00, lat);
    release_out();
    do_op(4'h2, 8'h01, 8'h02, lat);
    check("bp_latency", lat, 1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; op = 4'h2; acc_in = 8'hFF; reg_in = 8'hFF;
      @(posedge clk); #1;
      check($sformatf("bp%0d_result", i), result, 8'h03);
      check($sformatf("bp%0d_out_valid", i), out_valid, 1'b1);
      check($sformatf("bp%0d_in_ready", i), in_ready, 1'b0);
      check($sformatf("bp%0d_c", i), c, 1'b0);
    end
    in_valid = 1'b0;
    release_out();
    check("bp_after_in_ready", in_ready, 1'b1);
    check("bp_after_out_valid", out_valid, 1'b0);
    @(posedge clk); #1;
    check("bp_no_ghost_op", out_valid, 1'b0);

    // Reset during the third EXEC cycle of a popcount
    do_op(4'h2, 8'hF0, 8'h20, lat);
    check("pre_reset_c", c, 1'b1);
    release_out();
    in_valid = 1'b1; op = 4'h9; acc_in = 8'h00; reg_in = 8'hFF;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_flags", {z, c, n, v}, 4'b0000);
    check("midrst_result", result, 8'h00);
    check("midrst_in_ready", in_ready, 1'b1);
    #3;
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("postrst_out_valid", out_valid, 1'b0);
    check("postrst_in_ready", in_ready, 1'b1);
    do_op(4'h2, 8'h05, 8'h06, lat);
    check("postrst_add_result", result, 8'h0B);
    check("postrst_add_latency", lat, 1);
    check("postrst_add_c", c, 1'b0);
    release_out();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
